// File: rtl/cpu_subsys_sram_arb_if.sv
// Bundle of both requester ports and the SRAM-side port of the shared SRAM arbiter.
// Latency: none, wiring only.
// Backpressure: the slave modport is the arbiter's view; master is the environment's view.
interface cpu_subsys_sram_arb_if;
    logic        m0_valid;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_wstrb;
    logic        m0_ready;
    logic [31:0] m0_rdata;

    logic        m1_valid;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_wstrb;
    logic        m1_ready;
    logic [31:0] m1_rdata;

    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic [31:0] s_rdata;

    modport slave (
        input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
        input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
        input  s_ready, s_rdata,
        output m0_ready, m0_rdata, m1_ready, m1_rdata,
        output s_valid, s_addr, s_wdata, s_wstrb
    );

    modport master (
        output m0_valid, m0_addr, m0_wdata, m0_wstrb,
        output m1_valid, m1_addr, m1_wdata, m1_wstrb,
        output s_ready, s_rdata,
        input  m0_ready, m0_rdata, m1_ready, m1_rdata,
        input  s_valid, s_addr, s_wdata, s_wstrb
    );
endinterface

// File: rtl/cpu_subsys_sram_arb.sv
// Shares one single-port SRAM between port 0 (CPU) and port 1 (DMA/debug); CPU_SUBSYS_SRAM_ARB_RR_EN selects round-robin, else fixed priority to port 0.
// Latency: 3 cycles valid-to-ready plus one per SRAM wait state; one access per 4 cycles back-to-back.
// Backpressure: requests wait with valid held until granted; the SRAM request is held until s_ready.
module cpu_subsys_sram_arb #(
    parameter int ADDR_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    cpu_subsys_sram_arb_if.slave  bus
);

    localparam logic [31:0] ADDR_MASK = (ADDR_BITS >= 32) ? 32'hFFFF_FFFF
                                                          : ((32'd1 << ADDR_BITS) - 32'd1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        REC  = 2'd2
    } state_t;

    state_t      state;
    logic        grant_q;
    logic        s_valid_q;
    logic [31:0] s_addr_q;
    logic [31:0] s_wdata_q;
    logic [3:0]  s_wstrb_q;
    logic        m0_ready_q;
    logic        m1_ready_q;
    logic [31:0] m0_rdata_q;
    logic [31:0] m1_rdata_q;
`ifdef CPU_SUBSYS_SRAM_ARB_RR_EN
    logic        last_grant_q;
`endif

    logic        win;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic [3:0]  win_wstrb;

    // win is only consulted when at least one port is requesting.
    always_comb begin
        win = !bus.m0_valid;
`ifdef CPU_SUBSYS_SRAM_ARB_RR_EN
        if (bus.m0_valid && bus.m1_valid) begin
            win = !last_grant_q;
        end
`endif
        win_addr  = win ? bus.m1_addr  : bus.m0_addr;
        win_wdata = win ? bus.m1_wdata : bus.m0_wdata;
        win_wstrb = win ? bus.m1_wstrb : bus.m0_wstrb;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            grant_q      <= 1'b0;
            s_valid_q    <= 1'b0;
            s_addr_q     <= 32'd0;
            s_wdata_q    <= 32'd0;
            s_wstrb_q    <= 4'd0;
            m0_ready_q   <= 1'b0;
            m1_ready_q   <= 1'b0;
            m0_rdata_q   <= 32'd0;
            m1_rdata_q   <= 32'd0;
`ifdef CPU_SUBSYS_SRAM_ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.m0_valid || bus.m1_valid) begin
                        grant_q      <= win;
                        s_valid_q    <= 1'b1;
                        s_addr_q     <= win_addr & ADDR_MASK;
                        s_wdata_q    <= win_wdata;
                        s_wstrb_q    <= win_wstrb;
`ifdef CPU_SUBSYS_SRAM_ARB_RR_EN
                        last_grant_q <= win;
`endif
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.s_ready) begin
                        s_valid_q <= 1'b0;
                        if (grant_q) begin
                            m1_rdata_q <= bus.s_rdata;
                            m1_ready_q <= 1'b1;
                        end else begin
                            m0_rdata_q <= bus.s_rdata;
                            m0_ready_q <= 1'b1;
                        end
                        state <= REC;
                    end
                end
                // The SRAM's registered ready is still high here; requests
                // are deliberately not looked at so a completing port is not re-served.
                REC: begin
                    m0_ready_q <= 1'b0;
                    m1_ready_q <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.s_valid  = s_valid_q;
    assign bus.s_addr   = s_addr_q;
    assign bus.s_wdata  = s_wdata_q;
    assign bus.s_wstrb  = s_wstrb_q;
    assign bus.m0_ready = m0_ready_q;
    assign bus.m1_ready = m1_ready_q;
    assign bus.m0_rdata = m0_rdata_q;
    assign bus.m1_rdata = m1_rdata_q;

endmodule
